pooling_layer_ctrl: RTL

- Sequencer for the 2x2/stride-2 pooling datapath.
- Accepts convolution output rows through a valid/ready handshake and issues one kernel_calc_fin pulse per row, tagged with feature_idx/feature_row.
- Enforces minimum row spacing so the datapath clear/accumulate pipeline never overlaps.
- Tracks pooled-output emergence and signals frame completion after pipeline drain.

---
 rtl/pooling_layer_ctrl_pkg.sv | 24 ++
 rtl/pooling_layer_ctrl_if.sv | 30 +++
 rtl/pooling_layer_ctrl_delay_line.sv | 54 +++++
 rtl/pooling_layer_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pooling_layer_ctrl_pkg.sv
// Shared types and default geometry for the pooling sequencer.
// Defaults mirror the datapath's pooling_param values; change both together.
package pooling_ctrl_pkg;

    localparam int NUM_FEATURES = 3;   // feature maps per frame (1..4)
    localparam int FEATURE_ROWS = 6;   // conv rows per feature map (even, 2..8)
    localparam int ROW_GAP      = 4;   // minimum cycles between accepted rows
    localparam int PIPE_LATENCY = 4;   // kernel_calc_fin -> pooled output valid

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One pooled-row tag travelling alongside the datapath pipeline.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
        logic [1:0] prow;
    } tag_t;

endpackage

// File: rtl/pooling_layer_ctrl_if.sv
// Row handshake and datapath-facing tags of the pooling sequencer.
//
// Handshake: a row transfers on every rising clk edge where row_valid and
// row_ready are both 1. row_valid may rise or fall at any time and does not
// wait for row_ready; row_ready does not depend on row_valid. Each transfer
// produces exactly one kernel_calc_fin pulse on the following cycle.
interface pooling_layer_ctrl_if;
    logic       row_valid;
    logic       row_ready;
    logic       kernel_calc_fin;
    logic [1:0] feature_idx;
    logic [2:0] feature_row;
    logic       pool_out_valid;
    logic [1:0] pool_out_idx;
    logic [1:0] pool_out_row;

    // Row source / datapath observer side.
    modport master (
        output row_valid,
        input  row_ready, kernel_calc_fin, feature_idx, feature_row,
        input  pool_out_valid, pool_out_idx, pool_out_row
    );

    // Controller side.
    modport slave (
        input  row_valid,
        output row_ready, kernel_calc_fin, feature_idx, feature_row,
        output pool_out_valid, pool_out_idx, pool_out_row
    );
endinterface

// File: rtl/pooling_layer_ctrl_delay_line.sv
// Tag pipeline matching the pooling datapath latency. A stage only takes new
// idx/prow when the incoming entry is valid, so the output tags hold their
// last pooled value while no pooled row is present.
module pooling_ctrl_delay_line #(
    parameter int DEPTH = pooling_ctrl_pkg::PIPE_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  pooling_ctrl_pkg::tag_t din,
    output pooling_ctrl_pkg::tag_t dout,
    output logic                  empty
);
    import pooling_ctrl_pkg::*;

    tag_t stage [DEPTH];
    tag_t src   [DEPTH];

    // Source of each stage: the input for stage 0, the previous stage otherwise.
    always_comb begin
        src[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            src[i] = stage[i-1];
        end
    end

    // Shift register with asynchronous reset and synchronous flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i].valid <= src[i].valid;
                if (src[i].valid) begin
                    stage[i].idx  <= src[i].idx;
                    stage[i].prow <= src[i].prow;
                end
            end
        end
    end

    // Empty once the output stage shifts out: no valid entry behind it.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (stage[i].valid) empty = 1'b0;
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pooling_layer_ctrl.sv
// Sequencer for the 2x2/stride-2 pooling datapath: accepts conv rows with
// enforced spacing, pulses kernel_calc_fin per row, tracks pooled outputs
// and pulses done after the pipeline drains.
// Optional build macro POOL_CTRL_PERF_EN enables the stall_cnt counter;
// without it stall_cnt is constant 0.
module pooling_layer_ctrl #(
    parameter int NUM_FEATURES = pooling_ctrl_pkg::NUM_FEATURES,
    parameter int FEATURE_ROWS = pooling_ctrl_pkg::FEATURE_ROWS,
    parameter int ROW_GAP      = pooling_ctrl_pkg::ROW_GAP,
    parameter int PIPE_LATENCY = pooling_ctrl_pkg::PIPE_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    pooling_layer_ctrl_if.slave      bus,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              stall_cnt,
    output pooling_ctrl_pkg::state_t state_dbg
);
    import pooling_ctrl_pkg::*;

    localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q;
    logic [1:0]       feat_q;
    logic [2:0]       row_q;
    logic             fin_q;
    logic [1:0]       fidx_q;
    logic [2:0]       frow_q;
    logic             accept;
    logic             last_row;
    logic             dl_empty;
    tag_t             push_tag;
    tag_t             pool_tag;

    assign bus.row_ready = (state_q == RUN) && (gap_q == '0) && !abort;
    assign accept        = bus.row_valid && bus.row_ready;
    assign last_row      = accept && (feat_q == 2'(NUM_FEATURES - 1))
                                  && (row_q  == 3'(FEATURE_ROWS - 1));

    assign bus.kernel_calc_fin = fin_q && !abort;
    assign bus.feature_idx     = fidx_q;
    assign bus.feature_row     = frow_q;

    // An odd conv row completes a 2x2 window, so it yields one pooled row.
    always_comb begin
        push_tag       = '0;
        push_tag.valid = bus.kernel_calc_fin && frow_q[0];
        push_tag.idx   = fidx_q;
        push_tag.prow  = frow_q[2:1];
    end

    pooling_ctrl_delay_line #(.DEPTH(PIPE_LATENCY)) u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .din   (push_tag),
        .dout  (pool_tag),
        .empty (dl_empty)
    );

    assign bus.pool_out_valid = pool_tag.valid;
    assign bus.pool_out_idx   = pool_tag.idx;
    assign bus.pool_out_row   = pool_tag.prow;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; DRAIN leaves when the last pooled row is at the output so
    // done lands on the cycle right after it.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (last_row) state_d = DRAIN;
                DRAIN:   if (dl_empty && !push_tag.valid) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Row/feature counters, row spacing and the registered fin pulse/tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q  <= '0;
            feat_q <= '0;
            row_q  <= '0;
            fin_q  <= 1'b0;
            fidx_q <= '0;
            frow_q <= '0;
        end else if (abort) begin
            gap_q  <= '0;
            feat_q <= '0;
            row_q  <= '0;
            fin_q  <= 1'b0;
            fidx_q <= '0;
            frow_q <= '0;
        end else begin
            fin_q <= accept;
            if (state_q == IDLE && start) begin
                gap_q  <= '0;
                feat_q <= '0;
                row_q  <= '0;
            end else if (accept) begin
                gap_q  <= GAP_W'(ROW_GAP - 1);
                fidx_q <= feat_q;
                frow_q <= row_q;
                if (row_q == 3'(FEATURE_ROWS - 1)) begin
                    row_q  <= '0;
                    feat_q <= feat_q + 2'd1;
                end else begin
                    row_q <= row_q + 3'd1;
                end
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

`ifdef POOL_CTRL_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of RUN cycles where a row waits on the spacing gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (abort || (state_q == IDLE && start)) begin
            stall_q <= '0;
        end else if (state_q == RUN && bus.row_valid && !bus.row_ready
                     && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
